// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS-subset control FSM (lw, sw, R-type addu/subu,
// beq, ori, optional j). Moore-style state decode with a combinational funct
// decode in EXEC_R. Optional feature macro: MC_JUMP_EN enables the j opcode
// and the JUMP state; without it opcode 000010 is treated as illegal.
module mc_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pc_en,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_ctl,
    output logic        ext_op,
    output logic [1:0]  pc_src,
    output logic        halted,
    output logic [15:0] retired,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EXEC_R  = 4'd6,
        S_R_WB    = 4'd7,
        S_BRANCH  = 4'd8,
        S_EXEC_I  = 4'd9,
        S_I_WB    = 4'd10,
`ifdef MC_JUMP_EN
        S_JUMP    = 4'd11,
`endif
        S_HALT    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
`ifdef MC_JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] retired_q;
    logic        halted_q;
    logic        pc_write;
    logic        pc_write_cond;
    logic        ir_write_raw;
    logic        mem_write_raw;
    logic        reg_write_raw;
    logic        funct_ok;
    logic        retire;

    assign funct_ok = (funct == FN_ADDU) || (funct == FN_SUBU);

    // State register; synchronous reset returns to FETCH from any state.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADR;
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ORI:       state_d = S_EXEC_I;
`ifdef MC_JUMP_EN
                    OP_J:         state_d = S_JUMP;
`endif
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEM_ADR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  state_d = S_MEM_WB;
            S_EXEC_R:  state_d = funct_ok ? S_R_WB : S_HALT;
            S_EXEC_I:  state_d = S_I_WB;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH;
        endcase
    end

    // Per-state control outputs; everything not named for a state stays 0.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_ctl       = 2'b00;
        ext_op        = 1'b0;
        pc_src        = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read     = 1'b1;
                ir_write_raw = 1'b1;
                alu_src_b    = 2'b01;
                pc_write     = 1'b1;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                ext_op    = 1'b1;
            end
            S_MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = 1'b1;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_raw = 1'b1;
                mem_to_reg    = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_raw = 1'b1;
                i_or_d        = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_ctl   = (funct == FN_SUBU) ? 2'b01 : 2'b00;
            end
            S_R_WB: begin
                reg_write_raw = 1'b1;
                reg_dst       = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_ctl       = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctl   = 2'b10;
            end
            S_I_WB: begin
                reg_write_raw = 1'b1;
            end
`ifdef MC_JUMP_EN
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
            end
`endif
            default: ;
        endcase
    end

    // Instruction completes on the edge leaving any final state.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_MEM_WB, S_MEM_WR, S_R_WB, S_BRANCH, S_I_WB: retire = 1'b1;
`ifdef MC_JUMP_EN
            S_JUMP: retire = 1'b1;
`endif
            default: retire = 1'b0;
        endcase
    end

    // Retired counter (wraps naturally) and sticky halt flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            if (retire) retired_q <= retired_q + 16'd1;
            if (state_d == S_HALT) halted_q <= 1'b1;
        end
    end

    // Write/load strobes are suppressed combinationally while reset is held.
    assign pc_en     = (pc_write | (pc_write_cond & zero)) & ~rst;
    assign ir_write  = ir_write_raw & ~rst;
    assign mem_write = mem_write_raw & ~rst;
    assign reg_write = reg_write_raw & ~rst;
    assign halted    = halted_q;
    assign retired   = retired_q;
    assign state     = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expectations are queued when an
// instruction is issued and compared by a negedge monitor.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg;
    logic        reg_dst, reg_write, alu_src_a, ext_op, halted;
    logic [1:0]  alu_src_b, alu_ctl, pc_src;
    logic [15:0] retired;
    logic [3:0]  state;

    mc_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctl(alu_ctl), .ext_op(ext_op),
        .pc_src(pc_src), .halted(halted), .retired(retired), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] outs;
        logic [15:0] ret;
        logic        hlt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_ret = '0;
    logic        exp_halted = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected control bundle for a state:
    // {pc_en,i_or_d,mem_read,mem_write,ir_write,mem_to_reg,reg_dst,reg_write,
    //  alu_src_a,alu_src_b[1:0],alu_ctl[1:0],ext_op,pc_src[1:0]}
    function automatic logic [15:0] exp_outs(input logic [3:0] st, input logic [5:0] fn, input logic z);
        logic pe, iod, mr, mw, irw, m2r, rd, rw, sa, eo;
        logic [1:0] sbs, ac, ps;
        {pe, iod, mr, mw, irw, m2r, rd, rw, sa, eo} = '0;
        sbs = 2'b00; ac = 2'b00; ps = 2'b00;
        case (st)
            4'd0:  begin pe = 1'b1; mr = 1'b1; irw = 1'b1; sbs = 2'b01; end
            4'd1:  begin sbs = 2'b11; eo = 1'b1; end
            4'd2:  begin sa = 1'b1; sbs = 2'b10; eo = 1'b1; end
            4'd3:  begin mr = 1'b1; iod = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 1'b1; end
            4'd5:  begin mw = 1'b1; iod = 1'b1; end
            4'd6:  begin sa = 1'b1; ac = (fn == 6'b100011) ? 2'b01 : 2'b00; end
            4'd7:  begin rw = 1'b1; rd = 1'b1; end
            4'd8:  begin sa = 1'b1; ac = 2'b01; ps = 2'b01; pe = z; end
            4'd9:  begin sa = 1'b1; sbs = 2'b10; ac = 2'b10; end
            4'd10: begin rw = 1'b1; end
            4'd11: begin pe = 1'b1; ps = 2'b10; end
            default: ;
        endcase
        return {pe, iod, mr, mw, irw, m2r, rd, rw, sa, sbs, ac, eo, ps};
    endfunction

    // Drive one instruction (called in a FETCH cycle) and queue its expected
    // per-cycle behaviour. cut > 0 keeps only the first 'cut' cycles.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z, input int cut);
        logic [3:0] seq[$];
        exp_t e;
        opcode = op; funct = fn; zero = z;
        seq = {4'd0, 4'd1};
        case (op)
            6'b100011: begin seq.push_back(4'd2); seq.push_back(4'd3); seq.push_back(4'd4); end
            6'b101011: begin seq.push_back(4'd2); seq.push_back(4'd5); end
            6'b000000: begin
                seq.push_back(4'd6);
                if (fn == 6'b100001 || fn == 6'b100011) seq.push_back(4'd7);
                else seq.push_back(4'd12);
            end
            6'b000100: seq.push_back(4'd8);
            6'b001101: begin seq.push_back(4'd9); seq.push_back(4'd10); end
`ifdef MC_JUMP_EN
            6'b000010: seq.push_back(4'd11);
`endif
            default:   seq.push_back(4'd12);
        endcase
        if (seq[seq.size()-1] == 4'd12) begin
            seq.push_back(4'd12);
            seq.push_back(4'd12);
        end
        if (cut > 0) while (seq.size() > cut) void'(seq.pop_back());
        foreach (seq[i]) begin
            if (seq[i] == 4'd12) exp_halted = 1'b1;
            e.st   = seq[i];
            e.outs = exp_outs(seq[i], fn, z);
            e.ret  = exp_ret;
            e.hlt  = exp_halted;
            sb.push_back(e);
        end
        if (cut == 0 && seq[seq.size()-1] != 4'd12) exp_ret = exp_ret + 16'd1;
    endtask

    // Wait (bounded) for the scoreboard to empty, then move to the next cycle.
    task automatic drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) begin
            @(negedge clk); #1;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    // Apply reset from the current state for one edge, then release into FETCH.
    task automatic do_reset(input logic [3:0] st_before);
        rst = 1'b1;
        @(negedge clk);
        check("rst_hold_state", 32'(state), 32'(st_before));
        check("rst_gate", 32'({pc_en, ir_write, mem_write, reg_write}), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_gate_fetch", 32'({pc_en, ir_write}), 32'd0);
        exp_ret = '0;
        exp_halted = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Monitor: compare DUT against the oldest queued expectation each cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("state", 32'(state), 32'(e.st));
            check("outs", 32'({pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                               reg_dst, reg_write, alu_src_a, alu_src_b, alu_ctl,
                               ext_op, pc_src}), 32'(e.outs));
            check("retired", 32'(retired), 32'(e.ret));
            check("halted", 32'(halted), 32'(e.hlt));
        end
    end

    initial begin
        rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("init_state", 32'(state), 32'd0);
        check("init_retired", 32'(retired), 32'd0);
        check("init_halted", 32'(halted), 32'd0);
        check("init_gate", 32'({pc_en, ir_write, mem_write, reg_write}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        issue(6'b100011, 6'b000000, 1'b0, 0);  drain();  // lw
        issue(6'b000100, 6'b000000, 1'b1, 0);  drain();  // beq taken
        issue(6'b000100, 6'b000000, 1'b0, 0);  drain();  // beq not taken
        issue(6'b000000, 6'b100001, 1'b0, 0);  drain();  // addu
        issue(6'b000000, 6'b100011, 1'b0, 0);  drain();  // subu
        issue(6'b001101, 6'b000000, 1'b0, 0);  drain();  // ori
        issue(6'b101011, 6'b000000, 1'b0, 0);  drain();  // sw
        issue(6'b000010, 6'b000000, 1'b0, 0);  drain();  // j
`ifndef MC_JUMP_EN
        do_reset(4'd12);
`endif
        // reset while in MEM_WR
        issue(6'b101011, 6'b000000, 1'b0, 3);  drain();
        do_reset(4'd5);
        // illegal funct
        issue(6'b000000, 6'b111111, 1'b0, 0);  drain();
        do_reset(4'd12);
        // illegal opcode
        issue(6'b111111, 6'b000000, 1'b0, 0);  drain();
        do_reset(4'd12);

        // Counter wrap: preload near the top, then retire three stores.
        force dut.retired_q = 16'hFFFE;
        #1;
        release dut.retired_q;
        exp_ret = 16'hFFFE;
        issue(6'b101011, 6'b000000, 1'b0, 0);  drain();
        issue(6'b101011, 6'b000000, 1'b0, 0);  drain();
        issue(6'b101011, 6'b000000, 1'b0, 0);  drain();
        @(negedge clk);
        check("wrap_retired", 32'(retired), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
